// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int MIN_DIV = 2;
  function automatic logic [31:0] hi_len(input logic [31:0] d);
    return d - (d >> 1);
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with run/drain FSM and a single pending-ratio slot.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_d_o,
  output logic             tick_o,
  output logic             running_o
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, hi;
  logic pv_q, pv_d, clk_d_q, clk_d_d, tick_q, tick_d, idle, wrap, apply;
  assign idle = state_q == IDLE;
  assign wrap = !idle && cnt_q == div_q - CNT_W'(1);
  // Ratio swaps only on a period boundary, so the waveform never shows a runt pulse.
  assign apply = pv_q && (wrap || idle);
  assign hi = CNT_W'(hi_len(32'(div_q)));
  assign pend_o = pv_q;
  assign clk_d_o = clk_d_q;
  assign tick_o = tick_q;
  assign running_o = !idle;
  always_comb begin
    div_d   = apply ? pend_q : div_q;
    pend_d  = wr_i ? wr_div_i : pend_q;
    pv_d    = apply ? 1'b0 : (wr_i | pv_q);
    state_d = state_q;
    cnt_d   = '0;
    clk_d_d = 1'b0;
    tick_d  = 1'b0;
    if (idle || wrap) begin
      state_d = en_i ? RUN : IDLE;
      clk_d_d = en_i;
      tick_d  = en_i;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      clk_d_d = cnt_d < hi;
      state_d = en_i ? RUN : DRAIN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(DEFAULT_DIV);
      pend_q  <= '0;
      pv_q    <= 1'b0;
      clk_d_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      clk_d_q <= clk_d_d;
      tick_q  <= tick_d;
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable clock dividers sharing one ratio-config port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_d,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
);
  logic [NUM_CH-1:0] pend;
  logic ch_ok, div_ok, accept, err_q, err_d;
  assign ch_ok = int'(cfg_ch) < NUM_CH;
  assign div_ok = cfg_div >= CNT_W'(MIN_DIV);
  // Out-of-range channels are always accepted so the error can be reported.
  assign cfg_ready = ch_ok ? !pend[cfg_ch] : 1'b1;
  assign accept = cfg_valid & cfg_ready;
  assign err_d = accept & !(ch_ok & div_ok);
  assign cfg_err = err_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en[c]),
      .wr_i     (accept & ch_ok & div_ok & (cfg_ch == CH_W'(c))),
      .wr_div_i (cfg_div),
      .pend_o   (pend[c]),
      .clk_d_o  (clk_d[c]),
      .tick_o   (tick[c]),
      .running_o(running[c])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
endmodule
